// File: rtl/coinc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : coinc_pkg
//  Purpose  : Shared definitions for the coincidence report scheduler:
//             default bank geometry, sync byte, channel index map, FSM state
//             encoding and the frame-length helper.
//  Options  : COINC_REPORT_CHECKSUM_EN -- frames carry a trailing checksum.
//  Revision : 1.0 - initial release
// ============================================================================
package coinc_pkg;

   localparam int         N_CH_DEFAULT      = 8;
   localparam int         CNT_W_DEFAULT     = 32;
   localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

   // Counter-bank channel map (position of each counter in cnt_bus)
   localparam int CH_A    = 0;
   localparam int CH_B    = 1;
   localparam int CH_AP   = 2;
   localparam int CH_BP   = 3;
   localparam int CH_AB   = 4;
   localparam int CH_APBP = 5;
   localparam int CH_ABP  = 6;
   localparam int CH_APB  = 7;

`ifdef COINC_REPORT_CHECKSUM_EN
   localparam bit CSUM_EN = 1'b1;
`else
   localparam bit CSUM_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      ST_WAIT = 2'd0,
      ST_SYNC = 2'd1,
      ST_DATA = 2'd2,
      ST_CSUM = 2'd3
   } state_t;

   // Bytes per frame: sync + snapshot bytes (+ checksum when enabled)
   function automatic int frame_len(input int n_ch, input int cnt_w);
      return 1 + (n_ch * cnt_w) / 8 + (CSUM_EN ? 1 : 0);
   endfunction

endpackage
`default_nettype wire

// File: rtl/coinc_report_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module   : coinc_report_scheduler_if
//  Purpose  : Byte stream valid/ready link from the scheduler to the UART TX.
//  Ports    : tx_data  - byte offered
//             tx_valid - tx_data is valid
//             tx_ready - sink accepts the byte on this edge
//  Modports : master (scheduler side), slave (UART TX side)
//  Revision : 1.0 - initial release
// ============================================================================
interface coinc_report_scheduler_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   modport master (output tx_data, output tx_valid, input tx_ready);
   modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface
`default_nettype wire

// File: rtl/coinc_report_scheduler_window_timer.sv
`default_nettype none
// ============================================================================
//  Module   : window_timer
//  Purpose  : Integration-window counter. Counts 0..WINDOW_CYCLES-1 while
//             enable is high and wraps without gaps; held at 0 while enable
//             is low or in reset. tc marks the last cycle of a window.
//  Ports    : clk, rst_n (sync, active-low), enable, tc (terminal count)
//  Revision : 1.0 - initial release
// ============================================================================
module window_timer #(
   parameter int WINDOW_CYCLES = 100_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic enable,
   output logic tc
);

   localparam int            CW     = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;
   localparam logic [CW-1:0] c_last = CW'(WINDOW_CYCLES - 1);

   logic [CW-1:0] r_win_cnt;
   logic          w_at_last;

   assign w_at_last = (r_win_cnt == c_last);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_win_cnt <= '0;
      end else if (!enable || w_at_last) begin
         r_win_cnt <= '0;
      end else begin
         r_win_cnt <= r_win_cnt + CW'(1);
      end
   end

   // Gated by rst_n so the counter bank clear reduces to !enable in reset
   assign tc = rst_n && enable && w_at_last;

endmodule
`default_nettype wire

// File: rtl/coinc_report_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : coinc_report_scheduler
//  Purpose  : Once per integration window, snapshots and clears the
//             coincidence-counter bank, then streams a framed byte sequence
//             (SYNC, counters channel 0 first / LSB byte first, optional
//             checksum) to the UART TX over valid/ready.
//  Ports    : clk, rst_n (sync, active-low), enable (window run/stop),
//             cnt_bus (N_CH x CNT_W counters), cnt_clear (bank clear),
//             tx (byte stream master), busy, frame_done (pulse),
//             overrun (sticky: window ended mid-frame)
//  Options  : COINC_REPORT_CHECKSUM_EN -- append two's-complement checksum
//             of the data bytes.
//  Revision : 1.0 - initial release
// ============================================================================
module coinc_report_scheduler
   import coinc_pkg::*;
#(
   parameter int         N_CH          = N_CH_DEFAULT,
   parameter int         CNT_W         = CNT_W_DEFAULT,
   parameter int         WINDOW_CYCLES = 100_000_000,
   parameter logic [7:0] SYNC_BYTE     = SYNC_BYTE_DEFAULT
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     enable,
   input  logic [N_CH*CNT_W-1:0]    cnt_bus,
   output logic                     cnt_clear,
   coinc_report_scheduler_if.master tx,
   output logic                     busy,
   output logic                     frame_done,
   output logic                     overrun
);

   localparam int            NBYTES      = (N_CH * CNT_W) / 8;
   localparam int            IW          = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [IW-1:0] c_last_byte = IW'(NBYTES - 1);

   state_t                r_state;
   state_t                w_next_state;
   logic [N_CH*CNT_W-1:0] r_snap;
   logic [IW-1:0]         r_idx;
   logic                  r_frame_done;
   logic                  r_overrun;
   logic                  w_tc;
   logic                  w_tx_valid;
   logic [7:0]            w_tx_data;
   logic                  w_frame_end;
   logic                  w_data_accept;
   logic                  w_capture;

   window_timer #(
      .WINDOW_CYCLES (WINDOW_CYCLES)
   ) u_window_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .enable (enable),
      .tc     (w_tc)
   );

   // Clearing on tc lets the bank load that edge's increment, so no counts
   // are lost across the window boundary.
   assign cnt_clear     = w_tc || !enable;
   assign w_capture     = w_tc && (r_state == ST_WAIT);
   assign w_data_accept = (r_state == ST_DATA) && tx.tx_ready;

`ifdef COINC_REPORT_CHECKSUM_EN
   logic [7:0] r_csum;

   always_ff @(posedge clk) begin
      if (!rst_n || w_capture) begin
         r_csum <= '0;
      end else if (w_data_accept) begin
         r_csum <= r_csum + w_tx_data;
      end
   end
`endif

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_WAIT;
      end else begin
         r_state <= w_next_state;
      end
   end

   // tx_data/tx_valid are decoded from registered state only, so the
   // offered byte cannot change while the sink stalls.
   always_comb begin
      w_next_state = r_state;
      w_tx_valid   = 1'b0;
      w_tx_data    = '0;
      w_frame_end  = 1'b0;
      case (r_state)
         ST_WAIT: begin
            if (w_tc) begin
               w_next_state = ST_SYNC;
            end
         end
         ST_SYNC: begin
            w_tx_valid = 1'b1;
            w_tx_data  = SYNC_BYTE;
            if (tx.tx_ready) begin
               w_next_state = ST_DATA;
            end
         end
         ST_DATA: begin
            w_tx_valid = 1'b1;
            w_tx_data  = r_snap[{r_idx, 3'b000} +: 8];
            if (tx.tx_ready && (r_idx == c_last_byte)) begin
`ifdef COINC_REPORT_CHECKSUM_EN
               w_next_state = ST_CSUM;
`else
               w_next_state = ST_WAIT;
               w_frame_end  = 1'b1;
`endif
            end
         end
`ifdef COINC_REPORT_CHECKSUM_EN
         ST_CSUM: begin
            w_tx_valid = 1'b1;
            w_tx_data  = 8'h00 - r_csum;
            if (tx.tx_ready) begin
               w_next_state = ST_WAIT;
               w_frame_end  = 1'b1;
            end
         end
`endif
         default: begin
            w_next_state = ST_WAIT;
         end
      endcase
   end

   // ----------------------------------------------------------- datapath
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_snap       <= '0;
         r_idx        <= '0;
         r_frame_done <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         r_frame_done <= w_frame_end;
         // A window ending mid-frame is flagged; the running frame keeps
         // its original snapshot and the new window's data is dropped.
         if (w_tc && (r_state != ST_WAIT)) begin
            r_overrun <= 1'b1;
         end
         if (w_capture) begin
            r_snap <= cnt_bus;
            r_idx  <= '0;
         end else if (w_data_accept) begin
            r_idx <= (r_idx == c_last_byte) ? '0 : r_idx + IW'(1);
         end
      end
   end

   assign tx.tx_valid = w_tx_valid;
   assign tx.tx_data  = w_tx_data;
   assign busy        = (r_state != ST_WAIT);
   assign frame_done  = r_frame_done;
   assign overrun     = r_overrun;

endmodule
`default_nettype wire
